// File: rtl/pixel_arb_pkg.sv
// Shared widths, screen-size defaults and FSM state type for the pixel write
// arbiter that feeds the vga_adapter write port.
package pixel_arb_pkg;

  // vga_adapter coordinate and colour widths
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  // Default visible area: 160 x 120
  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  // ARB: serve requesters; CLEAR: full-screen fill sweep
  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// Round-robin selector: scans requests starting at ptr (wrapping) and returns
// the first asserted one as a one-hot pick. Purely combinational.
module rr_pick
  import pixel_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  // First asserted request at or after ptr wins; indices wrap past NUM_REQ-1.
  always_comb begin
    int idx;
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Pixel write arbiter: round-robin multiplexes NUM_REQ pixel requesters onto
// the single registered vga_adapter write port (x, y, colour, plot).
// Optional full-screen fill (CLEAR state, sweep counter, clear_busy) is
// compiled in only when PIXEL_ARB_CLEAR_EN is defined; otherwise the FSM stays
// in ARB, clear_start/clear_colour are ignored and clear_busy is 0.
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [X_W*NUM_REQ-1:0] req_x,
  input  logic [Y_W*NUM_REQ-1:0] req_y,
  input  logic [C_W*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]     grant,
  input  logic                   clear_start,
  input  logic [C_W-1:0]         clear_colour,
  output logic                   clear_busy,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot
);

  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [X_W-1:0]   X_LAST   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     ptr_reg, ptr_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic                 plot_reg, plot_next;
  logic                 busy_reg, busy_next;
  logic [X_W-1:0]       x_reg, x_next;
  logic [Y_W-1:0]       y_reg, y_next;
  logic [C_W-1:0]       colour_reg, colour_next;

`ifdef PIXEL_ARB_CLEAR_EN
  logic [X_W-1:0]       sweep_x_reg, sweep_x_next;
  logic [Y_W-1:0]       sweep_y_reg, sweep_y_next;
  logic [C_W-1:0]       fill_colour_reg, fill_colour_next;
`else
  // Fill inputs have no function in this build
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_colour};
`endif

  // Per-requester views of the packed data buses
  logic [X_W-1:0] req_x_arr      [NUM_REQ];
  logic [Y_W-1:0] req_y_arr      [NUM_REQ];
  logic [C_W-1:0] req_colour_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_x_arr[gi]      = req_x[X_W*gi +: X_W];
      assign req_y_arr[gi]      = req_y[Y_W*gi +: Y_W];
      assign req_colour_arr[gi] = req_colour[C_W*gi +: C_W];
    end
  endgenerate

  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [C_W-1:0]     sel_colour;
  logic               sel_visible;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Encode the one-hot pick back to an index for data muxing and ptr update
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  assign sel_x       = req_x_arr[pick_idx];
  assign sel_y       = req_y_arr[pick_idx];
  assign sel_colour  = req_colour_arr[pick_idx];
  // Off-screen pixels are consumed (granted) but never plotted
  assign sel_visible = (sel_x <= X_LAST) && (sel_y <= Y_LAST);

  // Next-state and next-output logic; write port holds its value when idle
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    grant_next  = '0;
    plot_next   = 1'b0;
    busy_next   = 1'b0;
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
`ifdef PIXEL_ARB_CLEAR_EN
    sweep_x_next     = sweep_x_reg;
    sweep_y_next     = sweep_y_reg;
    fill_colour_next = fill_colour_reg;
`endif
    case (state_reg)
      ARB: begin
`ifdef PIXEL_ARB_CLEAR_EN
        // A fill request beats any pending pixel; those stay ungranted
        if (clear_start) begin
          state_next       = CLEAR;
          sweep_x_next     = '0;
          sweep_y_next     = '0;
          fill_colour_next = clear_colour;
        end else if (pick_valid) begin
`else
        if (pick_valid) begin
`endif
          grant_next = pick;
          ptr_next   = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
          if (sel_visible) begin
            plot_next   = 1'b1;
            x_next      = sel_x;
            y_next      = sel_y;
            colour_next = sel_colour;
          end
        end
      end
`ifdef PIXEL_ARB_CLEAR_EN
      CLEAR: begin
        // Column-major sweep: y runs fastest, last pixel returns to ARB
        plot_next   = 1'b1;
        busy_next   = 1'b1;
        x_next      = sweep_x_reg;
        y_next      = sweep_y_reg;
        colour_next = fill_colour_reg;
        if (sweep_y_reg == Y_LAST) begin
          sweep_y_next = '0;
          if (sweep_x_reg == X_LAST) begin
            sweep_x_next = '0;
            state_next   = ARB;
          end else begin
            sweep_x_next = sweep_x_reg + 1'b1;
          end
        end else begin
          sweep_y_next = sweep_y_reg + 1'b1;
        end
      end
`endif
      default: begin
        state_next = ARB;
      end
    endcase
  end

  // State and registered write-port outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= ARB;
      ptr_reg    <= '0;
      grant_reg  <= '0;
      plot_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
`ifdef PIXEL_ARB_CLEAR_EN
      sweep_x_reg     <= '0;
      sweep_y_reg     <= '0;
      fill_colour_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      grant_reg  <= grant_next;
      plot_reg   <= plot_next;
      busy_reg   <= busy_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
`ifdef PIXEL_ARB_CLEAR_EN
      sweep_x_reg     <= sweep_x_next;
      sweep_y_reg     <= sweep_y_next;
      fill_colour_reg <= fill_colour_next;
`endif
    end
  end

  assign grant      = grant_reg;
  assign plot       = plot_reg;
  assign clear_busy = busy_reg;
  assign x          = x_reg;
  assign y          = y_reg;
  assign colour     = colour_reg;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: a cycle-level reference model
// (search-from-pointer arbitration, fill pixel n -> (n / rows, n % rows))
// is compared against the DUT every cycle, plus directed literal checks.
// Fill scenarios are exercised when PIXEL_ARB_CLEAR_EN is defined.
module tb_pixel_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int X_MAX   = 159;
  localparam int Y_MAX   = 119;
  localparam int ROWS    = Y_MAX + 1;
  localparam int TOTAL   = (X_MAX + 1) * (Y_MAX + 1);
`ifdef PIXEL_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic [3:0]  req          = '0;
  logic [31:0] req_x        = '0;
  logic [27:0] req_y        = '0;
  logic [11:0] req_colour   = '0;
  logic        clear_start  = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic [3:0]  grant;
  logic        clear_busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  pixel_write_arbiter dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_colour   (req_colour),
    .grant        (grant),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  logic       exp_plot, exp_busy;
  logic [3:0] exp_grant;
  logic [7:0] exp_x;
  logic [6:0] exp_y;
  logic [2:0] exp_col;
  int         m_ptr  = 0;
  bit         m_fill = 1'b0;
  int         m_n    = 0;
  logic [2:0] m_cc   = '0;
  int         m_sel;

  always @(posedge clk) begin
    m_sel = -1;
    if (reset) begin
      exp_plot <= 1'b0; exp_grant <= '0; exp_busy <= 1'b0;
      exp_x <= '0; exp_y <= '0; exp_col <= '0;
      m_ptr <= 0; m_fill <= 1'b0; m_n <= 0;
    end else if (m_fill) begin
      exp_plot <= 1'b1; exp_grant <= '0; exp_busy <= 1'b1;
      exp_x <= 8'(m_n / ROWS); exp_y <= 7'(m_n % ROWS); exp_col <= m_cc;
      m_n <= m_n + 1;
      if (m_n == TOTAL - 1) m_fill <= 1'b0;
    end else if (CLEAR_EN && clear_start) begin
      m_fill <= 1'b1; m_n <= 0; m_cc <= clear_colour;
      exp_plot <= 1'b0; exp_grant <= '0; exp_busy <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_sel < 0 && req[(m_ptr + k) % NUM_REQ]) m_sel = (m_ptr + k) % NUM_REQ;
      end
      exp_busy <= 1'b0;
      if (m_sel < 0) begin
        exp_plot <= 1'b0; exp_grant <= '0;
      end else begin
        exp_grant <= 4'(1 << m_sel);
        m_ptr <= (m_sel + 1) % NUM_REQ;
        if (int'(req_x[8*m_sel +: 8]) <= X_MAX && int'(req_y[7*m_sel +: 7]) <= Y_MAX) begin
          exp_plot <= 1'b1;
          exp_x    <= req_x[8*m_sel +: 8];
          exp_y    <= req_y[7*m_sel +: 7];
          exp_col  <= req_colour[3*m_sel +: 3];
        end else begin
          exp_plot <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (plot !== exp_plot || grant !== exp_grant || clear_busy !== exp_busy ||
          x !== exp_x || y !== exp_y || colour !== exp_col) begin
        n_bad++;
        if (n_bad < 30)
          $display("FAIL model t=%0t plot/grant/busy/x/y/colour got %b/%b/%b/%0d/%0d/%b want %b/%b/%b/%0d/%0d/%b",
                   $time, plot, grant, clear_busy, x, y, colour,
                   exp_plot, exp_grant, exp_busy, exp_x, exp_y, exp_col);
      end
    end
  end

  // ---------------- helpers ----------------
  logic [7:0] px [NUM_REQ];
  logic [6:0] py [NUM_REQ];
  logic [2:0] pc [NUM_REQ];
  bit         pend [NUM_REQ];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]              = pend[i];
      req_x[8*i +: 8]     = px[i];
      req_y[7*i +: 7]     = py[i];
      req_colour[3*i +: 3] = pc[i];
    end
  endtask

  task automatic set_px(input int i, input int vx, input int vy, input int vc);
    pend[i] = 1'b1;
    px[i] = 8'(vx); py[i] = 7'(vy); pc[i] = 3'(vc);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    drive();
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end else begin
      $display("txn %s = %0d ok", name, act);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int nplot, lx, ly, badcol, gdur;
  bit done, used_clear;
  int seq_exp [5];

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; px[i] = '0; py[i] = '0; pc[i] = '0;
    end
    seq_exp[0] = 1; seq_exp[1] = 2; seq_exp[2] = 4; seq_exp[3] = 8; seq_exp[4] = 1;
    drive();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_plot", int'(plot), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(clear_busy), 0);
    chk("rst_xyc", int'({x, y, colour}), 0);
    reset = 1'b0;

    // single pixel, one-cycle latency
    set_px(0, 10, 20, 1); drive();
    tick();
    chk("single_plot", int'(plot), 1);
    chk("single_x", int'(x), 10);
    chk("single_y", int'(y), 20);
    chk("single_col", int'(colour), 1);
    chk("single_grant", int'(grant), 1);
    clear_all();
    tick();
    chk("idle_plot", int'(plot), 0);
    chk("idle_grant", int'(grant), 0);
    chk("idle_hold_x", int'(x), 10);

    // all four held: rotate
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_px(i, 1 + i, 2 + i, i);
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_all_%0d", k), int'(grant), seq_exp[k]);
    end
    clear_all();

    // ptr=2 then req 0011
    do_reset();
    set_px(1, 30, 40, 2); drive();
    tick();
    chk("ptr_setup_grant", int'(grant), 2);
    set_px(0, 1, 2, 3); set_px(1, 31, 41, 4); drive();
    tick();
    chk("ptr2_first", int'(grant), 1);
    pend[0] = 1'b0; drive();
    tick();
    chk("ptr2_second", int'(grant), 2);
    chk("ptr2_second_x", int'(x), 31);
    clear_all();

    // off-screen pixels: granted, not plotted
    set_px(0, 160, 5, 7); drive();
    tick();
    chk("oob_x_grant", int'(grant), 1);
    chk("oob_x_plot", int'(plot), 0);
    clear_all();
    set_px(2, 3, 120, 7); drive();
    tick();
    chk("oob_y_grant", int'(grant), 4);
    chk("oob_y_plot", int'(plot), 0);
    clear_all();
    tick();

    // clear_start together with a pending request
    set_px(0, 5, 6, 2); drive();
    clear_start = 1'b1; clear_colour = 3'b101;
    tick();
    clear_start = 1'b0;
`ifdef PIXEL_ARB_CLEAR_EN
    chk("clr_accept_grant", int'(grant), 0);
    chk("clr_accept_plot", int'(plot), 0);
    nplot = 0; lx = -1; ly = -1; badcol = 0; gdur = 0; done = 1'b0;
    for (int c = 0; c < TOTAL + 50 && !done; c++) begin
      if (c == 100) begin clear_start = 1'b1; clear_colour = 3'b010; end
      else clear_start = 1'b0;
      tick();
      if (clear_busy && plot) begin
        nplot++; lx = int'(x); ly = int'(y);
        if (colour != 3'b101) badcol++;
      end
      if (grant != 4'b0000 && clear_busy) gdur++;
      if (!clear_busy && nplot > 0) done = 1'b1;
    end
    clear_start = 1'b0;
    chk("fill_count", nplot, TOTAL);
    chk("fill_last_x", lx, X_MAX);
    chk("fill_last_y", ly, Y_MAX);
    chk("fill_bad_colour", badcol, 0);
    chk("fill_grants", gdur, 0);
    chk("fill_end_grant", int'(grant), 1);
    chk("fill_end_x", int'(x), 5);
    clear_all();

    // reset mid-fill, then restart from origin
    do_reset();
    clear_start = 1'b1; clear_colour = 3'b011;
    tick();
    clear_start = 1'b0;
    nplot = 0;
    for (int c = 0; c < 6000 && nplot < 5000; c++) begin
      tick();
      if (plot) nplot++;
    end
    chk("abort_at", nplot, 5000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(clear_busy), 0);
    clear_start = 1'b1; clear_colour = 3'b110;
    tick();
    clear_start = 1'b0;
    tick();
    chk("restart_plot", int'(plot), 1);
    chk("restart_xy", int'({x, y}), 0);
    chk("restart_col", int'(colour), 6);
    tick();
    chk("restart_y1", int'(y), 1);
    do_reset();
`else
    chk("noclr_grant", int'(grant), 1);
    chk("noclr_busy", int'(clear_busy), 0);
    chk("noclr_x", int'(x), 5);
    clear_all();
    tick();
`endif

    // randomized traffic, model checked every cycle
    used_clear = 1'b0;
    for (int c = 0; c < 22000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_grant[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0)
          set_px(i, int'($urandom_range(0, 175)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
      end
      drive();
      reset = (!exp_busy && $urandom_range(0, 499) == 0);
      clear_start = 1'b0;
      if (c > 200 && c < 800 && !used_clear && $urandom_range(0, 199) == 0) begin
        clear_start  = 1'b1;
        clear_colour = 3'($urandom_range(0, 7));
        used_clear   = 1'b1;
      end else if ($urandom_range(0, 999) == 0 && exp_busy) begin
        clear_start  = 1'b1;
        clear_colour = 3'($urandom_range(0, 7));
      end
      tick();
    end
    reset = 1'b0;
    clear_start = 1'b0;
    clear_all();
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of pixel requesters.
REQ-002 Parameter X_MAX, default 159: last valid x coordinate.
REQ-003 Parameter Y_MAX, default 119: last valid y coordinate.
REQ-004 CLOCK_50  in  1  sole clock; every flop SHALL be rising-edge CLOCK_50.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  bit i high: requester i has one pixel pending.
REQ-007 req_x  in  8*NUM_REQ  packed x per requester; slice i is [8i+7:8i].
REQ-008 req_y  in  7*NUM_REQ  packed y per requester.
REQ-009 req_colour  in  3*NUM_REQ  packed colour per requester.
REQ-010 grant  out  NUM_REQ  one-hot, single-cycle pulse: requester i's pixel consumed.
REQ-011 clear_start  in  1  pulse requesting a full-screen fill.
REQ-012 clear_colour  in  3  fill colour, sampled on the accepted clear_start.
REQ-013 clear_busy  out  1  high while a fill is in progress.
REQ-014 x  out  8, y  out  7, colour  out  3, plot  out  1: registered write port to vga_adapter.

Function
REQ-015 The FSM SHALL have exactly two states: ARB and CLEAR.
REQ-016 In ARB, each cycle the arbiter SHALL pick one asserted req using round-robin priority starting at pointer ptr.
REQ-017 Latency: a request picked at edge k SHALL produce plot=1, its x/y/colour, and grant[i]=1 during cycle k+1 (all registered).
REQ-018 After granting i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL be unchanged when nothing is granted.
REQ-019 A requester SHALL hold req and data stable until grant; req still high in the cycle after grant is a new request.
REQ-020 Coordinates with x>X_MAX or y>Y_MAX: grant SHALL still pulse and plot SHALL stay 0 (pixel dropped).
REQ-021 No req asserted in ARB: plot=0 and grant=0 next cycle; x/y/colour hold their last values.
REQ-022 clear_start in ARB SHALL enter CLEAR next edge, latch clear_colour, set the sweep counter to (0,0); clear_start wins over simultaneous req, which stay pending without grant.
REQ-023 In CLEAR, plot SHALL be 1 every cycle, sweeping y 0..Y_MAX and then x+1, from (0,0) to (X_MAX,Y_MAX): exactly 19200 plotted cycles at defaults.
REQ-024 In CLEAR, grant SHALL be all zero and clear_start SHALL be ignored.
REQ-025 clear_busy SHALL be 1 in every cycle plot carries a fill pixel and SHALL drop in the cycle after (X_MAX,Y_MAX) is plotted; arbitration SHALL resume in that same cycle.
REQ-026 Sweep counters SHALL not wrap beyond X_MAX/Y_MAX; no coordinate outside the visible area is ever plotted.

Reset
REQ-027 With reset high at an edge: state=ARB, ptr=0, plot=0, grant=0, clear_busy=0, x=0, y=0, colour=0.
REQ-028 Reset mid-fill SHALL abort the fill immediately; the sweep position is not retained.

Configuration
REQ-029 Macro PIXEL_ARB_CLEAR_EN defined: the CLEAR state, the sweep counter, and REQ-022..REQ-026 are compiled in.
REQ-030 Macro undefined: ports are unchanged, clear_start and clear_colour are ignored, clear_busy is tied 0, and the FSM never leaves ARB.

Structure
REQ-031 Package pixel_arb_pkg SHALL hold the coordinate/colour widths, screen-size defaults, and the ARB/CLEAR state enum.
REQ-032 Combinational sub-module rr_pick (req, ptr -> one-hot pick, valid) SHALL implement the round-robin selection.

Verification
REQ-033 req=4'b0001, (10,20,3'b001) -> one cycle later plot=1, x=10, y=20, colour=001, grant=0001.
REQ-034 req=4'b1111 held -> grants cycle 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-035 ptr=2 with req=4'b0011 -> grant=0001 first, then 0010.
REQ-036 req0 with x=160 -> grant=0001 and plot=0.
REQ-037 clear_start with req=0001 in the same cycle -> 19200 plots of clear_colour ending at (159,119), no grant; then grant=0001 the cycle clear_busy falls.
REQ-038 Reset asserted at fill pixel 5000 -> next cycle plot=0 and clear_busy=0; a fresh clear_start restarts from (0,0).
